// File: rtl/result_drain_pkg.sv
// Shared state encodings, default geometry and index-width helper for result_drain.
// No logic; no latency or backpressure of its own.
package result_drain_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_WAIT = 2'd1,
    DRAIN_SEND = 2'd2
  } drain_state_e;

  localparam int BITWIDTH      = 32;
  localparam int SIZE          = 4;
  localparam int NUM_UNIT      = 1;
  localparam int NUM_CYCLE     = 8;
  localparam int LOG_NUM_CYCLE = 4;

  // A single-element result still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_word_mux.sv
// Registered N:1 word selector over the result vector; 1-cycle latency from sel/data.
// No flow control: reloads every cycle, so holding sel holds the word.
module drain_word_mux #(
  parameter int bitwidth = 32,
  parameter int n        = 4,
  parameter int iw       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [bitwidth*n-1:0] data,
  input  logic [iw-1:0]         sel,
  output logic [bitwidth-1:0]   word
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else begin
      word <= data[bitwidth*int'(sel) +: bitwidth];
    end
  end

endmodule

// File: rtl/result_drain.sv
// Waits numCycle after start, snapshots the accelerator result, streams it one word per handshake.
// out_valid never depends on out_ready; out_data/out_last hold while stalled.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int bitwidth    = BITWIDTH,
  parameter int size        = SIZE,
  parameter int numUnit     = NUM_UNIT,
  parameter int numCycle    = NUM_CYCLE,
  parameter int logNumCycle = LOG_NUM_CYCLE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [bitwidth*size*numUnit-1:0]  data_in_r,
  output logic [bitwidth-1:0]               out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overrun,
  input  logic                              clr_overrun
);

  localparam int N  = size * numUnit;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0]          IDX_LAST = IW'(N - 1);
  localparam logic [logNumCycle-1:0] LAT_END  = logNumCycle'(numCycle - 1);

  drain_state_e           state, state_nxt;
  logic [logNumCycle-1:0] lat_cnt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [bitwidth*N-1:0]  shadow, mux_src;
  logic                   hs, last_hs, capture, ignored_start;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    out_valid     = (state == DRAIN_SEND);
    busy          = (state != DRAIN_IDLE);
    out_last      = out_valid && (idx == IDX_LAST);
    hs            = out_valid && out_ready;
    last_hs       = hs && out_last;
    capture       = (state == DRAIN_WAIT) && (lat_cnt == LAT_END);
    ignored_start = start && ((state == DRAIN_WAIT) || (out_valid && !last_hs));
    case (state)
      DRAIN_IDLE: if (start) state_nxt = DRAIN_WAIT;
      DRAIN_WAIT: begin
        if (capture) begin
          state_nxt = DRAIN_SEND;
          idx_nxt   = '0;
        end
      end
      DRAIN_SEND: begin
        if (last_hs) begin
          state_nxt = start ? DRAIN_WAIT : DRAIN_IDLE;
          idx_nxt   = '0;
        end else if (hs) begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
    // The word register loads element 0 straight from the capture so valid data lines up with out_valid.
    mux_src = capture ? data_in_r : shadow;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DRAIN_IDLE;
      lat_cnt <= '0;
      idx     <= '0;
      shadow  <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if ((state_nxt == DRAIN_WAIT) && (state != DRAIN_WAIT)) begin
        lat_cnt <= '0;
      end else if ((state == DRAIN_WAIT) && !capture) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (capture) shadow <= data_in_r;
      if (ignored_start) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  drain_word_mux #(
    .bitwidth (bitwidth),
    .n        (N),
    .iw       (IW)
  ) u_word_mux (
    .clk  (clk),
    .rst  (rst),
    .data (mux_src),
    .sel  (idx_nxt),
    .word (out_data)
  );

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: table-driven runs, hand-written corner sequences, randomized traffic vs a queue model.
module tb_result_drain;

  localparam int BW  = 32;
  localparam int SZ  = 4;
  localparam int NU  = 2;
  localparam int NC  = 8;
  localparam int LNC = 4;
  localparam int N   = SZ * NU;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            out_ready = 1'b0;
  logic            clr_overrun = 1'b0;
  logic [BW*N-1:0] data_in_r = '0;
  logic [BW-1:0]   out_data;
  logic            out_valid, out_last, busy, overrun;

  always #5 clk = ~clk;

  result_drain #(
    .bitwidth    (BW),
    .size        (SZ),
    .numUnit     (NU),
    .numCycle    (NC),
    .logNumCycle (LNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in_r   (data_in_r),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference: cycles left until capture, queue of words still to deliver, sticky overrun.
  int            m_wait = 0;
  logic [BW-1:0] m_q[$];
  bit            m_ovr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_q.delete();
    m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    bit set_now;
    bit hs;
    bit fin;
    set_now = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    hs  = (m_q.size() > 0) && out_ready;
    fin = hs && (m_q.size() == 1);
    if (m_wait > 0) begin
      if (start) set_now = 1'b1;
      m_wait--;
      if (m_wait == 0)
        for (int i = 0; i < N; i++) m_q.push_back(data_in_r[BW*i +: BW]);
    end else if (m_q.size() > 0) begin
      if (hs) void'(m_q.pop_front());
      if (start) begin
        if (fin) m_wait = NC;
        else     set_now = 1'b1;
      end
    end else if (start) begin
      m_wait = NC;
    end
    if (set_now)          m_ovr = 1'b1;
    else if (clr_overrun) m_ovr = 1'b0;
  endtask

  task automatic check_model();
    chk("valid", out_valid, m_q.size() > 0);
    chk("busy", busy, (m_wait > 0) || (m_q.size() > 0));
    chk("overrun", overrun, m_ovr);
    if (m_q.size() > 0) begin
      chk("data", out_data, m_q[0]);
      chk("last", out_last, m_q.size() == 1);
    end else begin
      chk("last_idle", out_last, 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [BW*N-1:0] data;
    logic [15:0]     rdy_pat;
    bit              flood;
    int              exp_len;
  } row_t;

  row_t rows[5];
  logic [BW*N-1:0] d_seq, d_rand, d_rand2;

  // One run: start, ready from pattern during SEND, check words, last flag, rise time and run length.
  task automatic run_row(input row_t r, input int k);
    int c;
    int hs_cnt;
    int first_v;
    logic [BW*N-1:0] ref_data;
    ref_data  = r.data;
    data_in_r = r.data;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("row%0d_busy_start", k), busy, 1'b1);
    c = 0;
    hs_cnt = 0;
    first_v = -1;
    while (busy && c < 400) begin
      if (c >= NC && r.flood) data_in_r = '1;
      out_ready = (c >= NC) ? r.rdy_pat[(c - NC) % 16] : 1'b0;
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        if (hs_cnt < N) begin
          chk($sformatf("row%0d_word%0d", k, hs_cnt), out_data, ref_data[BW*hs_cnt +: BW]);
          chk($sformatf("row%0d_last%0d", k, hs_cnt), out_last, hs_cnt == N - 1);
        end
        hs_cnt++;
      end
      tick();
      c++;
    end
    out_ready = 1'b0;
    chk($sformatf("row%0d_len", k), c, r.exp_len);
    chk($sformatf("row%0d_handshakes", k), hs_cnt, N);
    chk($sformatf("row%0d_valid_rise", k), first_v, NC);
  endtask

  task automatic drain_idle(input string tag, input int exp_len, input int c0);
    int c;
    c = c0;
    while (busy && c < 400) begin
      tick();
      c++;
    end
    chk(tag, c, exp_len);
  endtask

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      d_seq[BW*i +: BW]   = 32'(i + 1);
      d_rand[BW*i +: BW]  = $urandom;
      d_rand2[BW*i +: BW] = $urandom;
    end
    rows[0] = '{d_seq,   16'hFFFF, 1'b0, 16};
    rows[1] = '{d_seq,   16'h9999, 1'b0, 24};
    rows[2] = '{d_rand,  16'hFFFF, 1'b1, 16};
    rows[3] = '{d_rand2, 16'h5555, 1'b1, 23};
    rows[4] = '{d_seq,   16'h8001, 1'b0, 72};

    #1 rst = 1'b0;
    model_reset();
    tick();
    tick();
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick();

    for (int r = 0; r < 5; r++) run_row(rows[r], r);

    // Ignored start at WAIT cycle 3; run still completes on time.
    data_in_r = d_seq;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovr_set", overrun, 1'b1);
    drain_idle("ovr_run_len", NC + N, 4);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clr", overrun, 1'b0);

    // Ignored start and clear in the same cycle: set wins.
    start = 1'b1;
    tick();
    start = 1'b1;
    clr_overrun = 1'b1;
    tick();
    start = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_set_wins", overrun, 1'b1);
    drain_idle("ovr2_run_len", NC + N, 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clr2", overrun, 1'b0);

    // Back-to-back: start in the final-handshake cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!(out_valid && out_last) && c < 60) begin
      tick();
      c++;
    end
    chk("b2b_reach_last", c, NC + N - 1);
    data_in_r = d_rand;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_overrun", overrun, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_valid", out_valid, 1'b0);
    c = 0;
    while (!out_valid && c < 60) begin
      tick();
      c++;
    end
    chk("b2b_valid_rise", c, NC);
    chk("b2b_first_word", out_data, d_rand[BW-1:0]);
    drain_idle("b2b_run_len", NC + N, NC);

    // Asynchronous reset in the middle of SEND with overrun set.
    data_in_r = d_seq;
    start = 1'b1;
    tick();
    tick(); tick();
    start = 1'b0;
    repeat (NC + 1) tick();
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_overrun", overrun, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_data", out_data, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      start       = ($urandom % 16) == 0;
      out_ready   = $urandom % 2;
      clr_overrun = ($urandom % 40) == 0;
      rst         = ($urandom % 400) != 0;
      for (int i = 0; i < N; i++) data_in_r[BW*i +: BW] = $urandom;
      tick();
    end
    rst = 1'b1;
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
    $fatal(1, "timeout");
  end

endmodule
